postfix_eval_sequencer: RTL and testbench
=========================================

# postfix_eval_sequencer

Sequential stack-machine controller for the expression evaluation datapath. It consumes a postfix token stream one token per handshake and sequences a shared 32-bit signed add/sub/multiply unit against an internal operand stack. It returns one result per expression with overflow and error status. It sits between the infix-to-postfix front end (token producer) and the result consumer, replacing the combinational whole-string postfix evaluation.

## Interface
- DEPTH, 16: operand stack entries (power of two, ≥2).
- MUL_CYCLES, 3: multiply latency in cycles (≥1).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tok_valid  in  1  token present.
- tok_ready  out  1  token accepted when tok_valid && tok_ready.
- tok_type  in  2  00 operand, 01 operator, 10 end-of-expression, 11 reserved (error).
- tok_data  in  32  operand value (two's complement), or operator code in [1:0]: 0 `+`, 1 `-`, 2 `*`, 3 illegal.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- result  out  32  signed result (low 32 bits of the true value).
- overflow  out  1  sticky: any signed overflow within this expression.
- error  out  1  malformed expression.
- depth  out  log2(DEPTH)+1  current stack occupancy.

## Operation
- States: RUN, MUL, DRAIN, DONE. Reset enters RUN with an empty stack and overflow/error internals cleared.
- tok_ready = 1 in RUN and DRAIN, 0 in MUL and DONE, 0 while rst is high.
- RUN, operand accepted:
  - push tok_data; depth+1.
  - If depth==DEPTH: set error, go to DRAIN.
- RUN, `+`/`-` accepted with depth≥2:
  - pop b (top), then a; push a op b; depth−1.
  - Overflow = signed overflow of the 32-bit op; OR it into sticky overflow.
- RUN, `*` accepted with depth≥2: latch a and b, go to MUL.
- MUL: count MUL_CYCLES cycles, then push the low 32 bits of a*b and return to RUN.
  - Overflow is set if the 64-bit signed product ≠ sign-extension of its low 32 bits.
- RUN, operator with depth<2, illegal operator code, or reserved tok_type:
  - set error; go to DRAIN (no stack change).
- RUN, end accepted:
  - depth==1: result=top, go to DONE.
  - otherwise: error=1, result=0, go to DONE.
- DRAIN: accept and discard tokens until end is accepted, then go to DONE with result=0, error=1.
- DONE: res_valid=1. result/overflow/error are held stable until res_ready.
  - On handshake: clear stack, sticky overflow and error; return to RUN.
- Arithmetic is 32-bit two's complement and wraps; overflow never alters the stored value.

## Timing
- Reset values: res_valid=0, result=0, overflow=0, error=0, depth=0, tok_ready=0 during reset. tok_ready=1 on the first cycle after rst falls.
- Operand, `+`, `-`: 1 token per cycle, zero bubbles.
- `*`: tok_ready low for exactly MUL_CYCLES cycles after the accept cycle.
- End token accepted in cycle N → res_valid=1 in cycle N+1.
- res_valid && res_ready in cycle M → res_valid=0 and tok_ready=1 in M+1. A handshake is valid in the very first cycle res_valid is high.
- One expression in flight; no token is accepted in DONE, so back-to-back expressions cost ≥1 bubble cycle.
- rst in any state (including mid-MUL or DONE with a pending result) aborts the work. The pending result is lost, and the state returns to reset values on the next edge.
- depth is registered and reflects the stack after the last completed push/pop. During MUL it shows the pre-pop value minus 2.

## Test plan
- Tokens for `5 6 + 20 + 3 4 + 10 + * 3 2 * -`, tok_valid always high, MUL_CYCLES=3:
  - result=521, overflow=0, error=0.
  - res_valid 1 cycle after end.
  - total stall cycles = 6 (two multiplies).
- `2147483647 1 +` end → result=0x80000000, overflow=1, error=0.
- `65536 65536 *` end → result=0, overflow=1.
- Next expression `3 4 -` → result=−1, overflow=0 (sticky flag cleared by the handshake).
- `1 +` then `9` then end:
  - error at `+`, DRAIN consumes `9`.
  - result=0, error=1.
  - following `7` end → result=7, error=0.
- DEPTH=4, push 5 operands then end → error=1 at 5th push; `1 2` end → error=1 (depth 2).
- Hold res_ready=0 for 10 cycles in DONE: outputs stable, tok_ready=0. Assert rst during a MUL stall: next cycle res_valid=0, depth=0, tok_ready=0, then 1 after release.

Source files
------------

// File: rtl/postfix_eval_sequencer.sv
// postfix_eval_sequencer
//
// Stack-machine controller that evaluates a postfix token stream, one token
// per valid/ready handshake, against an internal operand stack. Add and
// subtract complete in the accept cycle. Multiply is sequenced over
// MUL_CYCLES stall cycles. One result per expression is returned with sticky
// signed-overflow and malformed-expression status.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | accepting operands/operators/end, stack updated per token
// MUL   | multiply in progress, operands latched, token input stalled
// DRAIN | expression found malformed, discarding tokens up to end
// DONE  | result presented, waiting for consumer handshake
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   tok_valid  token present
//   tok_ready  token accepted when tok_valid && tok_ready
//   tok_type   00 operand, 01 operator, 10 end, 11 reserved
//   tok_data   operand value, or operator code in [1:0] (+ - * illegal)
//   res_valid  result available
//   res_ready  consumer accepts result
//   result     signed result, low 32 bits
//   overflow   sticky signed overflow within the expression
//   error      malformed expression
//   depth      current stack occupancy

module postfix_eval_sequencer #(
    parameter int DEPTH      = 16,
    parameter int MUL_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tok_valid,
    output logic                     tok_ready,
    input  logic [1:0]               tok_type,
    input  logic [31:0]              tok_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              result,
    output logic                     overflow,
    output logic                     error,
    output logic [$clog2(DEPTH):0]   depth
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(MUL_CYCLES - 1);

    localparam logic [1:0] TT_OPND = 2'b00;
    localparam logic [1:0] TT_OPER = 2'b01;
    localparam logic [1:0] TT_END  = 2'b10;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MUL   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Datapath action selected by the FSM for the current cycle.
    typedef enum logic [3:0] {
        ACT_NONE,
        ACT_PUSH,
        ACT_ADDSUB,
        ACT_MUL_START,
        ACT_MUL_WAIT,
        ACT_MUL_DONE,
        ACT_ERR,
        ACT_END_OK,
        ACT_END_BAD,
        ACT_CLEAR
    } act_t;

    state_t                state_q;
    state_t                state_nx;
    act_t                  act;

    logic [31:0]           stack_q [DEPTH];
    logic [DW-1:0]         depth_q;
    logic                  ovf_q;
    logic                  err_q;
    logic [31:0]           result_q;
    logic [CW-1:0]         cnt_q;
    logic signed [31:0]    mul_a_q;
    logic signed [31:0]    mul_b_q;

    logic                  tok_acc;
    logic [AW-1:0]         top_idx;
    logic [AW-1:0]         sec_idx;
    logic [AW-1:0]         push_idx;
    logic [31:0]           top_val;
    logic [31:0]           sec_val;
    logic [31:0]           sum;
    logic [31:0]           diff;
    logic [31:0]           as_res;
    logic                  as_ovf;
    logic signed [63:0]    prod;
    logic                  mul_ovf;

    logic                  stack_we;
    logic [AW-1:0]         stack_wa;
    logic [31:0]           stack_wd;

    // ------------------------------------------------------------------
    // Stack addressing and arithmetic
    // ------------------------------------------------------------------
    // When depth==DEPTH the low AW bits wrap to zero, so depth-1 still
    // lands on the top entry.
    assign top_idx  = AW'(depth_q - DW'(1));
    assign sec_idx  = AW'(depth_q - DW'(2));
    assign push_idx = depth_q[AW-1:0];
    assign top_val  = stack_q[top_idx];
    assign sec_val  = stack_q[sec_idx];

    // a is the second entry, b the top: result is a op b.
    assign sum  = sec_val + top_val;
    assign diff = sec_val - top_val;

    always_comb begin
        as_res = sum;
        as_ovf = 1'b0;
        if (tok_data[1:0] == OP_SUB) begin
            as_res = diff;
            as_ovf = (sec_val[31] != top_val[31]) && (diff[31] != sec_val[31]);
        end else begin
            as_ovf = (sec_val[31] == top_val[31]) && (sum[31] != sec_val[31]);
        end
    end

    // The product is formed from the latched operands; the MUL stall gives
    // the multiplier MUL_CYCLES cycles to settle before it is written back.
    assign prod    = mul_a_q * mul_b_q;
    assign mul_ovf = (prod[63:32] != {32{prod[31]}});

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, handshake outputs, datapath action
    // ------------------------------------------------------------------
    always_comb begin
        state_nx  = state_q;
        act       = ACT_NONE;
        tok_ready = 1'b0;
        res_valid = 1'b0;
        if (!rst) begin
            tok_ready = (state_q == RUN) || (state_q == DRAIN);
            res_valid = (state_q == DONE);
        end
        tok_acc = tok_valid && tok_ready;

        case (state_q)
            RUN: begin
                if (tok_acc) begin
                    case (tok_type)
                        TT_OPND: begin
                            if (depth_q == DEPTH_FULL) begin
                                act      = ACT_ERR;
                                state_nx = DRAIN;
                            end else begin
                                act = ACT_PUSH;
                            end
                        end
                        TT_OPER: begin
                            if ((depth_q < DW'(2)) ||
                                ((tok_data[1:0] != OP_ADD) &&
                                 (tok_data[1:0] != OP_SUB) &&
                                 (tok_data[1:0] != OP_MUL))) begin
                                act      = ACT_ERR;
                                state_nx = DRAIN;
                            end else if (tok_data[1:0] == OP_MUL) begin
                                act      = ACT_MUL_START;
                                state_nx = MUL;
                            end else begin
                                act = ACT_ADDSUB;
                            end
                        end
                        TT_END: begin
                            state_nx = DONE;
                            if (depth_q == DW'(1)) begin
                                act = ACT_END_OK;
                            end else begin
                                act = ACT_END_BAD;
                            end
                        end
                        default: begin
                            act      = ACT_ERR;
                            state_nx = DRAIN;
                        end
                    endcase
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    act      = ACT_MUL_DONE;
                    state_nx = RUN;
                end else begin
                    act = ACT_MUL_WAIT;
                end
            end
            DRAIN: begin
                if (tok_acc && (tok_type == TT_END)) begin
                    act      = ACT_END_BAD;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (res_valid && res_ready) begin
                    act      = ACT_CLEAR;
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand stack storage (contents are don't-care above depth)
    // ------------------------------------------------------------------
    always_comb begin
        stack_we = 1'b0;
        stack_wa = push_idx;
        stack_wd = tok_data;
        case (act)
            ACT_PUSH: begin
                stack_we = 1'b1;
            end
            ACT_ADDSUB: begin
                stack_we = 1'b1;
                stack_wa = sec_idx;
                stack_wd = as_res;
            end
            ACT_MUL_DONE: begin
                stack_we = 1'b1;
                stack_wd = prod[31:0];
            end
            default: begin
                stack_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (stack_we) begin
            stack_q[stack_wa] <= stack_wd;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy, status and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            case (act)
                ACT_PUSH: begin
                    depth_q <= depth_q + DW'(1);
                end
                ACT_ADDSUB: begin
                    depth_q <= depth_q - DW'(1);
                    ovf_q   <= ovf_q | as_ovf;
                end
                ACT_MUL_START: begin
                    mul_a_q <= sec_val;
                    mul_b_q <= top_val;
                    depth_q <= depth_q - DW'(2);
                    cnt_q   <= CNT_LOAD;
                end
                ACT_MUL_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                end
                ACT_MUL_DONE: begin
                    depth_q <= depth_q + DW'(1);
                    ovf_q   <= ovf_q | mul_ovf;
                end
                ACT_ERR: begin
                    err_q <= 1'b1;
                end
                ACT_END_OK: begin
                    result_q <= top_val;
                end
                ACT_END_BAD: begin
                    result_q <= '0;
                    err_q    <= 1'b1;
                end
                ACT_CLEAR: begin
                    depth_q  <= '0;
                    ovf_q    <= 1'b0;
                    err_q    <= 1'b0;
                    result_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign result   = result_q;
    assign overflow = ovf_q;
    assign error    = err_q;
    assign depth    = depth_q;

endmodule

// File: tb/tb_postfix_eval_sequencer.sv
module tb_postfix_eval_sequencer;

    localparam int DEPTH      = 4;
    localparam int MUL_CYCLES = 3;

    localparam logic [1:0] T_OPND = 2'b00;
    localparam logic [1:0] T_OPER = 2'b01;
    localparam logic [1:0] T_END  = 2'b10;
    localparam logic [1:0] T_RSVD = 2'b11;

    logic        clk;
    logic        rst;
    logic        tok_valid;
    logic        tok_ready;
    logic [1:0]  tok_type;
    logic [31:0] tok_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic        overflow;
    logic        error;
    logic [2:0]  depth;

    postfix_eval_sequencer #(
        .DEPTH      (DEPTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_type  (tok_type),
        .tok_data  (tok_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .overflow  (overflow),
        .error     (error),
        .depth     (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [1:0]  t;
        logic [31:0] d;
    } tok_t;

    typedef struct packed {
        logic [7:0]  first;
        logic [7:0]  count;
        logic [31:0] res;
        logic        ovf;
        logic        err;
        logic [7:0]  stalls;
    } exp_t;

    tok_t toks [128];
    exp_t exps [32];
    int   ntok;
    int   nexp;
    int   first_tok;

    int   checks;
    int   errors;
    int   stalls;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // table builders
    task automatic add_tok(input logic [1:0] t, input logic [31:0] d);
        toks[ntok].t = t;
        toks[ntok].d = d;
        ntok++;
    endtask

    task automatic begin_expr();
        first_tok = ntok;
    endtask

    task automatic end_expr(input logic [31:0] r, input logic o, input logic e, input int s);
        add_tok(T_END, 32'd0);
        exps[nexp].first  = 8'(first_tok);
        exps[nexp].count  = 8'(ntok - first_tok);
        exps[nexp].res    = r;
        exps[nexp].ovf    = o;
        exps[nexp].err    = e;
        exps[nexp].stalls = 8'(s);
        nexp++;
    endtask

    // Offers one token from the negedge, counting cycles it is refused.
    // tok_valid stays high afterwards so successive calls are back-to-back.
    task automatic send(input logic [1:0] t, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        tok_valid = 1'b1;
        tok_type  = t;
        tok_data  = d;
        while (!tok_ready && n < 50) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        chk("send_accept", 32'(tok_ready), 32'd1);
        if (tok_ready) @(posedge clk);
    endtask

    // Called right after the end token was accepted.
    task automatic wait_result(input string nm, input logic [31:0] r, input logic o, input logic e);
        @(negedge clk);
        tok_valid = 1'b0;
        chk({nm, "_res_valid"}, 32'(res_valid), 32'd1);
        chk({nm, "_result"}, result, r);
        chk({nm, "_overflow"}, 32'(overflow), 32'(o));
        chk({nm, "_error"}, 32'(error), 32'(e));
        chk({nm, "_tok_ready_done"}, 32'(tok_ready), 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({nm, "_res_valid_after"}, 32'(res_valid), 32'd0);
        chk({nm, "_tok_ready_after"}, 32'(tok_ready), 32'd1);
        chk({nm, "_depth_after"}, 32'(depth), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        stalls    = 0;
        ntok      = 0;
        nexp      = 0;
        first_tok = 0;
        rst       = 1'b1;
        tok_valid = 1'b0;
        tok_type  = 2'b00;
        tok_data  = 32'd0;
        res_ready = 1'b0;

        // ---------------- vector table ----------------
        // 5 6 + 20 + 3 4 + 10 + * 3 2 * -  = 31*17 - 6
        begin_expr();
        add_tok(T_OPND, 32'd5);  add_tok(T_OPND, 32'd6);  add_tok(T_OPER, 32'd0);
        add_tok(T_OPND, 32'd20); add_tok(T_OPER, 32'd0);
        add_tok(T_OPND, 32'd3);  add_tok(T_OPND, 32'd4);  add_tok(T_OPER, 32'd0);
        add_tok(T_OPND, 32'd10); add_tok(T_OPER, 32'd0);  add_tok(T_OPER, 32'd2);
        add_tok(T_OPND, 32'd3);  add_tok(T_OPND, 32'd2);  add_tok(T_OPER, 32'd2);
        add_tok(T_OPER, 32'd1);
        end_expr(32'd521, 1'b0, 1'b0, 6);
        // max positive + 1
        begin_expr();
        add_tok(T_OPND, 32'h7fffffff); add_tok(T_OPND, 32'd1); add_tok(T_OPER, 32'd0);
        end_expr(32'h80000000, 1'b1, 1'b0, 0);
        // 2^16 * 2^16
        begin_expr();
        add_tok(T_OPND, 32'd65536); add_tok(T_OPND, 32'd65536); add_tok(T_OPER, 32'd2);
        end_expr(32'd0, 1'b1, 1'b0, 3);
        // sticky overflow cleared by the previous handshake
        begin_expr();
        add_tok(T_OPND, 32'd3); add_tok(T_OPND, 32'd4); add_tok(T_OPER, 32'd1);
        end_expr(32'hffffffff, 1'b0, 1'b0, 0);
        // operator underflow, then drain 9
        begin_expr();
        add_tok(T_OPND, 32'd1); add_tok(T_OPER, 32'd0); add_tok(T_OPND, 32'd9);
        end_expr(32'd0, 1'b0, 1'b1, 0);
        begin_expr();
        add_tok(T_OPND, 32'd7);
        end_expr(32'd7, 1'b0, 1'b0, 0);
        // stack full on 5th push
        begin_expr();
        add_tok(T_OPND, 32'd1); add_tok(T_OPND, 32'd2); add_tok(T_OPND, 32'd3);
        add_tok(T_OPND, 32'd4); add_tok(T_OPND, 32'd5);
        end_expr(32'd0, 1'b0, 1'b1, 0);
        // two values left at end
        begin_expr();
        add_tok(T_OPND, 32'd1); add_tok(T_OPND, 32'd2);
        end_expr(32'd0, 1'b0, 1'b1, 0);
        // reserved token type
        begin_expr();
        add_tok(T_RSVD, 32'd0);
        end_expr(32'd0, 1'b0, 1'b1, 0);
        // illegal operator code
        begin_expr();
        add_tok(T_OPND, 32'd1); add_tok(T_OPND, 32'd2); add_tok(T_OPER, 32'd3);
        end_expr(32'd0, 1'b0, 1'b1, 0);
        // empty expression
        begin_expr();
        end_expr(32'd0, 1'b0, 1'b1, 0);
        // -3 * 7
        begin_expr();
        add_tok(T_OPND, 32'hfffffffd); add_tok(T_OPND, 32'd7); add_tok(T_OPER, 32'd2);
        end_expr(32'hffffffeb, 1'b0, 1'b0, 3);
        // min negative - 1
        begin_expr();
        add_tok(T_OPND, 32'h80000000); add_tok(T_OPND, 32'd1); add_tok(T_OPER, 32'd1);
        end_expr(32'h7fffffff, 1'b1, 1'b0, 0);
        // min negative * -1
        begin_expr();
        add_tok(T_OPND, 32'h80000000); add_tok(T_OPND, 32'hffffffff); add_tok(T_OPER, 32'd2);
        end_expr(32'h80000000, 1'b1, 1'b0, 3);
        // 46340^2 fits, 46341^2 does not
        begin_expr();
        add_tok(T_OPND, 32'd46340); add_tok(T_OPND, 32'd46340); add_tok(T_OPER, 32'd2);
        end_expr(32'h7ffea810, 1'b0, 1'b0, 3);
        begin_expr();
        add_tok(T_OPND, 32'd46341); add_tok(T_OPND, 32'd46341); add_tok(T_OPER, 32'd2);
        end_expr(32'h80001219, 1'b1, 1'b0, 3);

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        chk("rst_tok_ready", 32'(tok_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_tok_ready", 32'(tok_ready), 32'd1);

        // ---------------- table loop ----------------
        for (int e = 0; e < nexp; e++) begin
            stalls = 0;
            for (int k = 0; k < int'(exps[e].count); k++) begin
                send(toks[int'(exps[e].first) + k].t, toks[int'(exps[e].first) + k].d);
            end
            wait_result($sformatf("expr%0d", e), exps[e].res, exps[e].ovf, exps[e].err);
            chk($sformatf("expr%0d_stalls", e), 32'(stalls), 32'(exps[e].stalls));
        end

        // ---------------- error flagged at the bad operator ----------------
        send(T_OPND, 32'd1);
        send(T_OPER, 32'd0);
        @(negedge clk);
        tok_valid = 1'b0;
        chk("bad_op_error", 32'(error), 32'd1);
        chk("bad_op_depth", 32'(depth), 32'd1);
        chk("bad_op_drain_ready", 32'(tok_ready), 32'd1);
        send(T_OPND, 32'd9);
        send(T_END, 32'd0);
        wait_result("bad_op", 32'd0, 1'b0, 1'b1);

        // ---------------- DONE held with res_ready low ----------------
        send(T_OPND, 32'd8);
        send(T_END, 32'd0);
        @(negedge clk);
        tok_valid = 1'b1;
        tok_type  = T_OPND;
        tok_data  = 32'd99;
        for (int i = 0; i < 10; i++) begin
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_result", result, 32'd8);
            chk("hold_tok_ready", 32'(tok_ready), 32'd0);
            @(negedge clk);
        end
        tok_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("hold_after_res_valid", 32'(res_valid), 32'd0);
        chk("hold_after_depth", 32'(depth), 32'd0);
        chk("hold_after_tok_ready", 32'(tok_ready), 32'd1);

        // ---------------- reset during a multiply stall ----------------
        send(T_OPND, 32'd2);
        send(T_OPND, 32'd3);
        send(T_OPER, 32'd2);
        @(negedge clk);
        chk("mul_depth", 32'(depth), 32'd0);
        chk("mul_tok_ready", 32'(tok_ready), 32'd0);
        tok_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mul_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mul_rst_depth", 32'(depth), 32'd0);
        chk("mul_rst_tok_ready", 32'(tok_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mul_rst_release_ready", 32'(tok_ready), 32'd1);
        chk("mul_rst_release_depth", 32'(depth), 32'd0);
        send(T_OPND, 32'd7);
        send(T_END, 32'd0);
        wait_result("post_mul_rst", 32'd7, 1'b0, 1'b0);

        // ---------------- reset drops a pending result ----------------
        send(T_OPND, 32'd5);
        send(T_END, 32'd0);
        @(negedge clk);
        tok_valid = 1'b0;
        chk("done_rst_pre_valid", 32'(res_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("done_rst_res_valid", 32'(res_valid), 32'd0);
        chk("done_rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("done_rst_tok_ready", 32'(tok_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
